// File: rtl/icache_refill_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types and constants for the instruction-cache refill
//                bridge: FSM state encoding, line geometry, bus widths and
//                the word-address helper.
//  Revision    : 1.0  initial release
// ============================================================================
package icache_pkg;

    localparam int LINE_WORDS = 4;                  // words per cache line
    localparam int BEAT_W     = 2;                  // bits to index a word in a line
    localparam int WADDR_W    = 18;                 // backing-memory word address width
    localparam int CADDR_W    = 20;                 // cache byte address width
    localparam int DATA_W     = 32;                 // instruction word width
    localparam int BASE_W     = WADDR_W - BEAT_W;   // line base width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_RD   = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Word address of a beat: the word index wraps inside the line so a
    // critical-word-first fetch never leaves the requested line.
    function automatic logic [WADDR_W-1:0] word_addr(
        input logic [BASE_W-1:0] base,
        input logic [BEAT_W-1:0] start,
        input logic [BEAT_W-1:0] beat
    );
        logic [BEAT_W-1:0] widx;
        widx = start + beat;
        return {base, widx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_bridge_if
//  Description : Cache-side request/return channel and backing-memory read
//                channel of the refill bridge. The slave modport is the
//                bridge's view, the master modport is the surrounding
//                cache/memory environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_refill_bridge_if;
    import icache_pkg::*;

    // cache side
    logic               req;
    logic [CADDR_W-1:0] c_addr;
    logic               ack;
    logic               valid;
    logic [DATA_W-1:0]  data;
    // backing-memory side
    logic               mem_cs;
    logic [WADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_rdy;
    // status
    logic               busy;
    logic               err;

    modport slave (
        input  req, c_addr, mem_rdata, mem_rdy,
        output ack, valid, data, mem_cs, mem_addr, busy, err
    );

    modport master (
        output req, c_addr, mem_rdata, mem_rdy,
        input  ack, valid, data, mem_cs, mem_addr, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/icache_refill_bridge_timer.sv
`default_nettype none
// ============================================================================
//  Module      : refill_timer
//  Description : Per-beat wait-state watchdog. Counts enabled cycles from 0
//                and flags expiry on the TIMEOUT-th cycle (count TIMEOUT-1).
//  Revision    : 1.0  initial release
// ============================================================================
module refill_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cycle counter: restarts from 0 whenever the beat is not being waited on.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != C_LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/icache_refill_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_bridge
//  Description : Memory-side refill stage of the instruction cache. Accepts a
//                line request, fetches the 4-word line one word per beat
//                (critical word first when CWF=1) and returns each word as a
//                single-cycle valid pulse. A per-beat watchdog completes hung
//                beats with zero data and raises a sticky error.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_refill_bridge
    import icache_pkg::*;
#(
    parameter bit CWF     = 1'b1,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    icache_refill_bridge_if.slave bus
);

    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [BASE_W-1:0]   base_q,  base_d;
    logic [BEAT_W-1:0]   start_q, start_d;
    logic                err_q,   err_d;
    logic                armed_q, armed_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    logic                w_in_rd;
    logic                w_expire;
    logic                w_unused_caddr;

    // Byte-offset bits never affect which word is fetched.
    assign w_unused_caddr = ^bus.c_addr[1:0];

    assign w_in_rd = (state_q == ST_RD);

    refill_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!w_in_rd),
        .enable_i (w_in_rd),
        .expire_o (w_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values; mem_rdy wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        start_d = start_q;
        err_d   = err_q;
        armed_d = armed_q;
        valid_d = 1'b0;
        data_d  = data_q;

        // A dropped request re-arms the bridge so a held req never refills twice.
        if (!bus.req) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req && armed_q) begin
                    state_d = ST_ACK;
                    base_d  = bus.c_addr[CADDR_W-1:4];
                    start_d = CWF ? bus.c_addr[3:2] : 2'b00;
                    err_d   = 1'b0;
                    armed_d = 1'b0;
                end
            end
            ST_ACK: begin
                beat_d  = '0;
                state_d = ST_RD;
            end
            ST_RD: begin
                if (bus.mem_rdy) begin
                    valid_d = 1'b1;
                    data_d  = bus.mem_rdata;
                    state_d = ST_GAP;
                end else if (w_expire) begin
                    valid_d = 1'b1;
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (beat_q == C_LAST_BEAT) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = ST_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: line address, beat counter, returned word, flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q  <= '0;
            base_q  <= '0;
            start_q <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            beat_q  <= beat_d;
            base_q  <= base_d;
            start_q <= start_d;
            err_q   <= err_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.ack      = (state_q == ST_ACK);
    assign bus.mem_cs   = w_in_rd;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.mem_addr = word_addr(base_q, start_q, beat_q);
    assign bus.valid    = valid_q;
    assign bus.data     = data_q;
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_bridge
//  Description : Self-checking bench for icache_refill_bridge. Two instances
//                (CWF=1 and CWF=0) see the same request and wait-state
//                stream; each beat's address, timing, returned data and error
//                flag are predicted from the line/wrap rules and the
//                per-beat wait count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_refill_bridge;
    import icache_pkg::*;

    localparam int TIMEOUT = 8;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        tb_req  = 1'b0;
    logic [19:0] tb_addr = '0;
    logic        tb_rdy  = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          beat_wait [4];
    logic        err_exp  = 1'b0;
    logic [31:0] last_a   = '0;
    logic [31:0] last_b   = '0;

    icache_refill_bridge_if if_a ();
    icache_refill_bridge_if if_b ();

    // Backing memory: each word's content is a fixed scramble of its address.
    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign if_a.req       = tb_req;
    assign if_a.c_addr    = tb_addr;
    assign if_a.mem_rdy   = tb_rdy;
    assign if_a.mem_rdata = mem_word(if_a.mem_addr);
    assign if_b.req       = tb_req;
    assign if_b.c_addr    = tb_addr;
    assign if_b.mem_rdy   = tb_rdy;
    assign if_b.mem_rdata = mem_word(if_b.mem_addr);

    icache_refill_bridge #(.CWF(1'b1), .TIMEOUT(TIMEOUT)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    icache_refill_bridge #(.CWF(1'b0), .TIMEOUT(TIMEOUT)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line rule: base = addr[19:4], first word = addr[3:2] (CWF) or 0, wrap mod 4.
    function automatic logic [17:0] exp_addr(input logic [19:0] addr, input bit cwf, input int beat);
        int unsigned a;
        int unsigned line_base;
        int unsigned first;
        a         = 32'(addr);
        line_base = a / 16;
        first     = cwf ? (a / 4) % 4 : 0;
        return 18'(line_base * 4 + (first + 32'(beat)) % 4);
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy_a"},  32'(if_a.busy),   32'd0);
        check_eq({tag, "_busy_b"},  32'(if_b.busy),   32'd0);
        check_eq({tag, "_ack_a"},   32'(if_a.ack),    32'd0);
        check_eq({tag, "_ack_b"},   32'(if_b.ack),    32'd0);
        check_eq({tag, "_cs_a"},    32'(if_a.mem_cs), 32'd0);
        check_eq({tag, "_cs_b"},    32'(if_b.mem_cs), 32'd0);
        check_eq({tag, "_valid_a"}, 32'(if_a.valid),  32'd0);
        check_eq({tag, "_valid_b"}, 32'(if_b.valid),  32'd0);
        check_eq({tag, "_err_a"},   32'(if_a.err),    32'(err_exp));
        check_eq({tag, "_data_a"},  if_a.data,        last_a);
        check_eq({tag, "_data_b"},  if_b.data,        last_b);
    endtask

    // One full line refill; beat_wait[k] = idle mem_rdy cycles before the
    // beat's ready (>= TIMEOUT means the memory never answers that beat).
    task automatic run_line(input logic [19:0] addr, input bit hold_req);
        int   w;
        int   n_rd;
        bit   timed_out;
        logic [17:0] ea;
        logic [17:0] eb;
        if (tb_req) begin
            tb_req = 1'b0;
            tick();
            check_idle("rearm");
        end
        tb_req  = 1'b1;
        tb_addr = addr;
        tick();
        err_exp = 1'b0;
        check_eq("ack_a",      32'(if_a.ack),    32'd1);
        check_eq("ack_b",      32'(if_b.ack),    32'd1);
        check_eq("ack_busy",   32'(if_a.busy),   32'd1);
        check_eq("ack_cs",     32'(if_a.mem_cs), 32'd0);
        check_eq("ack_valid",  32'(if_a.valid),  32'd0);
        check_eq("ack_err_a",  32'(if_a.err),    32'd0);
        check_eq("ack_err_b",  32'(if_b.err),    32'd0);
        if (!hold_req) tb_req = 1'b0;
        tb_addr = 20'($urandom);
        tb_rdy  = 1'($urandom_range(0, 1));
        tick();
        for (int beat = 0; beat < 4; beat++) begin
            w         = beat_wait[beat];
            timed_out = (w >= TIMEOUT);
            n_rd      = timed_out ? TIMEOUT : w + 1;
            ea        = exp_addr(addr, 1'b1, beat);
            eb        = exp_addr(addr, 1'b0, beat);
            for (int c = 0; c < n_rd; c++) begin
                check_eq("rd_cs_a",    32'(if_a.mem_cs),   32'd1);
                check_eq("rd_cs_b",    32'(if_b.mem_cs),   32'd1);
                check_eq("rd_addr_a",  32'(if_a.mem_addr), 32'(ea));
                check_eq("rd_addr_b",  32'(if_b.mem_addr), 32'(eb));
                check_eq("rd_valid_a", 32'(if_a.valid),    32'd0);
                check_eq("rd_ack_a",   32'(if_a.ack),      32'd0);
                check_eq("rd_busy_b",  32'(if_b.busy),     32'd1);
                check_eq("rd_hold_a",  if_a.data,          last_a);
                check_eq("rd_err_a",   32'(if_a.err),      32'(err_exp));
                tb_rdy  = (c == w);
                tb_addr = 20'($urandom);
                tick();
            end
            if (timed_out) err_exp = 1'b1;
            last_a = timed_out ? 32'd0 : mem_word(ea);
            last_b = timed_out ? 32'd0 : mem_word(eb);
            check_eq("gap_valid_a", 32'(if_a.valid),  32'd1);
            check_eq("gap_valid_b", 32'(if_b.valid),  32'd1);
            check_eq("gap_data_a",  if_a.data,        last_a);
            check_eq("gap_data_b",  if_b.data,        last_b);
            check_eq("gap_cs_a",    32'(if_a.mem_cs), 32'd0);
            check_eq("gap_busy_a",  32'(if_a.busy),   32'd1);
            check_eq("gap_err_a",   32'(if_a.err),    32'(err_exp));
            check_eq("gap_err_b",   32'(if_b.err),    32'(err_exp));
            tb_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        check_idle("end");
    endtask

    initial begin
        // Reset values.
        tick();
        check_eq("rst_ack",   32'(if_a.ack),      32'd0);
        check_eq("rst_valid", 32'(if_a.valid),    32'd0);
        check_eq("rst_cs",    32'(if_a.mem_cs),   32'd0);
        check_eq("rst_busy",  32'(if_a.busy),     32'd0);
        check_eq("rst_err",   32'(if_a.err),      32'd0);
        check_eq("rst_data",  if_a.data,          32'd0);
        check_eq("rst_addr",  32'(if_a.mem_addr), 32'd0);
        check_eq("rst_addr_b", 32'(if_b.mem_addr), 32'd0);
        reset = 1'b0;
        tick();
        check_idle("post_rst");

        // Zero-wait critical-word-first line: 0x048E, 0x048F, 0x048C, 0x048D.
        beat_wait = '{0, 0, 0, 0};
        run_line(20'h01238, 1'b0);
        check_eq("t1_last_addr", 32'(exp_addr(20'h01238, 1'b1, 2)), 32'h048C);

        // Three wait states per beat.
        beat_wait = '{3, 3, 3, 3};
        run_line(20'h5A5A4, 1'b0);

        // Hung second beat: zero data, sticky err, then cleared by next ack.
        beat_wait = '{0, 100, 1, 0};
        run_line(20'h0FFFC, 1'b0);
        repeat (3) begin
            tick();
            check_idle("err_sticky");
        end
        beat_wait = '{TIMEOUT - 1, 0, 0, 2};
        run_line(20'h00010, 1'b0);

        // Held request: one ack only, until req drops for a cycle.
        beat_wait = '{0, 1, 0, 1};
        run_line(20'hABCD8, 1'b1);
        repeat (20) begin
            tb_rdy = 1'($urandom_range(0, 1));
            tick();
            check_idle("held");
        end
        run_line(20'hABCD4, 1'b0);

        // Reset during the second beat's read.
        tb_req  = 1'b1;
        tb_addr = 20'h33334;
        tick();
        check_eq("rst_mid_ack", 32'(if_a.ack), 32'd1);
        tb_req = 1'b0;
        tick();
        tb_rdy = 1'b1;
        tick();
        tb_rdy = 1'b0;
        tick();
        check_eq("rst_mid_rd", 32'(if_a.mem_cs), 32'd1);
        tb_rdy = 1'b1;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        tb_rdy = 1'b0;
        err_exp = 1'b0;
        last_a  = '0;
        last_b  = '0;
        check_eq("rst_mid_addr", 32'(if_a.mem_addr), 32'd0);
        check_idle("rst_mid");
        repeat (4) begin
            tick();
            check_idle("rst_after");
        end

        // Sequential (CWF=0) ordering from an end-of-line address.
        beat_wait = '{0, 0, 0, 0};
        run_line(20'h0000C, 1'b0);

        // Randomized lines: addresses, waits (incl. TIMEOUT-1 and hangs), held req.
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 4; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)      beat_wait[k] = r;
                else if (r < 6) beat_wait[k] = TIMEOUT - 1;
                else if (r < 8) beat_wait[k] = $urandom_range(4, 6);
                else            beat_wait[k] = TIMEOUT + r;
            end
            run_line(20'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) begin
                tb_rdy = 1'($urandom_range(0, 1));
                tick();
                check_idle("gap_idle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
